// File: rtl/tone_synth.sv
// Square-wave tone generator: Hz request -> half-period via a bit-serial restoring divider,
// with period updates deferred to a toggle boundary so the waveform never glitches.
module tone_synth #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned FREQ_W = 32,
  parameter int unsigned MIN_HZ = 20,
  parameter int unsigned MAX_HZ = 20000
) (
  input  logic              FPGA_CLK1_50,
  input  logic              reset,
  input  logic [FREQ_W-1:0] desiredFrequency,
  input  logic              enable,
  output logic              spkr,
  output logic              tone_active,
  output logic              busy,
  output logic [FREQ_W-1:0] half_period
);

  localparam int unsigned CW = $clog2(FREQ_W + 1);
  localparam logic [FREQ_W-1:0] NUM    = FREQ_W'(CLK_HZ / 2);
  localparam logic [FREQ_W-1:0] MIN_F  = FREQ_W'(MIN_HZ);
  localparam logic [FREQ_W-1:0] MAX_F  = FREQ_W'(MAX_HZ);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  // One restoring-division step; returns {remainder, quotient/dividend shift register}.
  function automatic logic [2*FREQ_W-1:0] div_step(input logic [FREQ_W-1:0] rem,
                                                   input logic [FREQ_W-1:0] quo,
                                                   input logic [FREQ_W-1:0] den);
    logic [FREQ_W:0]   trial;
    logic [FREQ_W-1:0] rem_n;
    logic              qbit;
    trial = {rem, quo[FREQ_W-1]};
    if (trial >= {1'b0, den}) begin
      rem_n = FREQ_W'(trial - {1'b0, den});
      qbit  = 1'b1;
    end else begin
      rem_n = trial[FREQ_W-1:0];
      qbit  = 1'b0;
    end
    return {rem_n, quo[FREQ_W-2:0], qbit};
  endfunction

  logic [FREQ_W-1:0]   f_q;
  logic [1:0]          state_q, state_d;
  logic [FREQ_W-1:0]   cur_f_q, cur_f_d;
  logic [FREQ_W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [FREQ_W-1:0]   pend_q, pend_d;
  logic [FREQ_W-1:0]   hp_q, hp_d;
  logic [FREQ_W-1:0]   cnt_q, cnt_d;
  logic                spkr_q, spkr_d;
  logic                act_q, act_d;
  logic                busy_q, busy_d;
  logic                f_valid;
  logic [2*FREQ_W-1:0] div_nxt;

  assign f_valid = (f_q >= MIN_F) && (f_q <= MAX_F);
  assign div_nxt = div_step(rem_q, quo_q, cur_f_q);

  always_comb begin
    state_d = state_q;
    cur_f_d = cur_f_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bit_d   = bit_q;
    pend_d  = pend_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    spkr_d  = spkr_q;
    act_d   = act_q;
    busy_d  = busy_q;
    if (!f_valid) begin
      state_d = S_IDLE;
      cur_f_d = '0;
      busy_d  = 1'b0;
      pend_d  = '0;
      hp_d    = '0;
      cnt_d   = '0;
      spkr_d  = 1'b0;
      act_d   = 1'b0;
    end else begin
      if (state_q == S_DIV) begin
        {rem_d, quo_d} = div_nxt;
        bit_d          = bit_q - CW'(1);
        if (bit_q == CW'(1)) begin
          pend_d  = div_nxt[FREQ_W-1:0];
          busy_d  = 1'b0;
          state_d = S_RUN;
        end
      end else if (f_q != cur_f_q) begin
        state_d = S_DIV;
        cur_f_d = f_q;
        rem_d   = '0;
        quo_d   = NUM;
        bit_d   = CW'(FREQ_W);
        busy_d  = 1'b1;
      end
      // Tone counter runs off the committed period, independent of any division in flight.
      if (pend_q != '0) begin
        if (!enable || !act_q) begin
          spkr_d = enable;
          act_d  = enable;
          hp_d   = pend_q;
          cnt_d  = pend_q - 1'b1;
        end else if (cnt_q == '0) begin
          spkr_d = ~spkr_q;
          hp_d   = pend_q;
          cnt_d  = pend_q - 1'b1;
        end else begin
          cnt_d  = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cur_f_q <= '0;
      pend_q  <= '0;
      hp_q    <= '0;
      cnt_q   <= '0;
      spkr_q  <= 1'b0;
      act_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_f_q <= cur_f_d;
      pend_q  <= pend_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      spkr_q  <= spkr_d;
      act_q   <= act_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge FPGA_CLK1_50) begin
    f_q   <= desiredFrequency;
    rem_q <= rem_d;
    quo_q <= quo_d;
    bit_q <= bit_d;
  end

  assign spkr        = spkr_q;
  assign tone_active = act_q;
  assign busy        = busy_q;
  assign half_period = hp_q;

endmodule
